// File: rtl/bus_arbiter8way16.sv
// bus_arbiter8way16: round-robin arbiter sharing one 16-bit valid/ready channel among eight lanes in bursts of up to MAX_BURST beats
module bus_arbiter8way16 #(
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   req,
  input  logic [127:0] din,
  input  logic         out_ready,
  output logic [7:0]   gnt,
  output logic [2:0]   sel,
  output logic [15:0]  out_data,
  output logic         out_valid,
  output logic         out_last
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);
  state_t state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d, ptr_q, ptr_d, base, win;
  logic [3:0] cnt_q, cnt_d;
  logic active, xfer, grant_end, rearb;
  assign active = state_q == GRANT;
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign out_valid = active && req[sel_q];
  assign out_data = active ? din[{sel_q, 4'b0000} +: 16] : 16'h0000;
  assign out_last = out_valid && cnt_q == LAST;
  assign xfer = out_valid && out_ready;
  assign grant_end = active && (!req[sel_q] || (xfer && cnt_q == LAST));
  assign rearb = !active || grant_end;
  // Searching downward leaves the lowest offset from base as the final winner.
  always_comb begin
    base = active ? sel_q + 3'd1 : ptr_q;
    win = base;
    for (int k = 7; k >= 0; k--) win = req[base + 3'(k)] ? base + 3'(k) : win;
  end
  always_comb begin
    state_d = rearb ? (|req ? GRANT : IDLE) : state_q;
    sel_d = (rearb && |req) ? win : sel_q;
    ptr_d = grant_end ? sel_q + 3'd1 : ptr_q;
    cnt_d = grant_end ? 4'd0 : cnt_q + 4'(xfer);
    gnt_d = state_d == GRANT ? 8'd1 << sel_d : 8'h00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_bus_arbiter8way16.sv
// tb_bus_arbiter8way16: scoreboard bench for the round-robin arbiter, MAX_BURST=4 and MAX_BURST=1 instances
module tb_bus_arbiter8way16;
  logic clk, reset, out_ready;
  logic [7:0] req4, req1, gnt4, gnt1;
  logic [127:0] din;
  logic [2:0] sel4, sel1;
  logic [15:0] data4, data1;
  logic valid4, valid1, last4, last1;
  int checks = 0, failures = 0;
  typedef struct {logic [2:0] sel; logic [15:0] data; logic last;} beat_t;
  beat_t sbq[$];

  bus_arbiter8way16 #(.MAX_BURST(4)) dut4 (.clk(clk), .reset(reset), .req(req4), .din(din),
    .out_ready(out_ready), .gnt(gnt4), .sel(sel4), .out_data(data4), .out_valid(valid4), .out_last(last4));
  bus_arbiter8way16 #(.MAX_BURST(1)) dut1 (.clk(clk), .reset(reset), .req(req1), .din(din),
    .out_ready(out_ready), .gnt(gnt1), .sel(sel1), .out_data(data1), .out_valid(valid1), .out_last(last1));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 0; req4 = 0; req1 = 0; din = '0; out_ready = 0;
    #2 reset = 1;
    #1;
    checks++;
    if (gnt4 !== 8'h00 || sel4 !== 3'd0) begin failures++; $display("FAIL reset_gnt_sel gnt=%h sel=%0d want 00/0", gnt4, sel4); end
    checks++;
    if (valid4 !== 1'b0 || data4 !== 16'h0000 || last4 !== 1'b0) begin failures++; $display("FAIL reset_outputs valid=%b data=%h last=%b want 0/0000/0", valid4, data4, last4); end
    @(negedge clk); reset = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (gnt4 !== 8'h00 || sel4 !== 3'd0 || valid4 !== 1'b0 || data4 !== 16'h0000) begin
        failures++; $display("FAIL idle gnt=%h sel=%0d valid=%b data=%h want 00/0/0/0000", gnt4, sel4, valid4, data4);
      end
    end
  endtask

  task automatic test_single_burst();
    beat_t b;
    @(negedge clk);
    din[47:32] = 16'h3456; req4 = 8'h04; out_ready = 1;
    for (int i = 0; i < 4; i++) sbq.push_back('{3'd2, 16'h3456, i == 3});
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h04 || sel4 !== 3'd2) begin failures++; $display("FAIL single_grant gnt=%h sel=%0d want 04/2", gnt4, sel4); end
    for (int c = 0; c < 12 && sbq.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      if (valid4 && out_ready) begin
        b = sbq.pop_front(); checks++;
        if (sel4 !== b.sel || data4 !== b.data || last4 !== b.last) begin
          failures++; $display("FAIL single_beat sel=%0d data=%h last=%b want %0d/%h/%b", sel4, data4, last4, b.sel, b.data, b.last);
        end
      end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL single_timeout left=%0d want 0", sbq.size()); end
    sbq.delete();
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h04 || sel4 !== 3'd2 || valid4 !== 1'b1 || last4 !== 1'b0) begin
      failures++; $display("FAIL single_regrant gnt=%h sel=%0d valid=%b last=%b want 04/2/1/0", gnt4, sel4, valid4, last4);
    end
    req4 = 0;
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h00 || valid4 !== 1'b0) begin failures++; $display("FAIL single_release gnt=%h valid=%b want 00/0", gnt4, valid4); end
  endtask

  task automatic test_contention();
    beat_t b;
    logic [15:0] lane;
    int n = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      lane = 16'h1234 + 16'(i) * 16'h1111;
      din[16*i +: 16] = lane;
    end
    req1 = 8'hFF; out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      lane = 16'h1234 + 16'(i % 8) * 16'h1111;
      sbq.push_back('{3'(i % 8), lane, 1'b1});
    end
    for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
      @(negedge clk); n++;
      if (valid1 && out_ready) begin
        b = sbq.pop_front(); checks++;
        if (sel1 !== b.sel || data1 !== b.data || last1 !== b.last) begin
          failures++; $display("FAIL contention_beat sel=%0d data=%h last=%b want %0d/%h/%b", sel1, data1, last1, b.sel, b.data, b.last);
        end
      end
    end
    checks++;
    if (sbq.size() != 0 || n != 9) begin failures++; $display("FAIL contention_rate cycles=%0d left=%0d want 9/0", n, sbq.size()); end
    sbq.delete();
    req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    beat_t b;
    @(negedge clk);
    din[95:80] = 16'hA5A5; din[15:0] = 16'h0F0F; req4 = 8'h20; out_ready = 1;
    for (int i = 0; i < 4; i++) sbq.push_back('{3'd5, 16'hA5A5, i == 3});
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h20 || sel4 !== 3'd5) begin failures++; $display("FAIL bp_grant gnt=%h sel=%0d want 20/5", gnt4, sel4); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (valid4 && out_ready) begin
        b = sbq.pop_front(); checks++;
        if (sel4 !== b.sel || data4 !== b.data || last4 !== b.last) begin
          failures++; $display("FAIL bp_beat sel=%0d data=%h last=%b want %0d/%h/%b", sel4, data4, last4, b.sel, b.data, b.last);
        end
      end
    end
    @(negedge clk);
    out_ready = 0; req4 = 8'h21;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (gnt4 !== 8'h20 || valid4 !== 1'b1 || data4 !== 16'hA5A5 || last4 !== 1'b1) begin
        failures++; $display("FAIL bp_stall gnt=%h valid=%b data=%h last=%b want 20/1/a5a5/1", gnt4, valid4, data4, last4);
      end
    end
    @(negedge clk);
    out_ready = 1;
    if (valid4 && out_ready && sbq.size() > 0) begin
      b = sbq.pop_front(); checks++;
      if (gnt4 !== 8'h20 || data4 !== b.data || last4 !== b.last) begin
        failures++; $display("FAIL bp_resume gnt=%h data=%h last=%b want 20/%h/%b", gnt4, data4, last4, b.data, b.last);
      end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL bp_left left=%0d want 0", sbq.size()); end
    sbq.delete();
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h01 || sel4 !== 3'd0 || data4 !== 16'h0F0F || valid4 !== 1'b1) begin
      failures++; $display("FAIL bp_handover gnt=%h sel=%0d data=%h valid=%b want 01/0/0f0f/1", gnt4, sel4, data4, valid4);
    end
    req4 = 0;
    @(negedge clk);
  endtask

  task automatic test_drop_pointer();
    beat_t b;
    @(negedge clk);
    din[63:48] = 16'h3333; din[111:96] = 16'h6666; req4 = 8'h08; out_ready = 1;
    for (int i = 0; i < 2; i++) sbq.push_back('{3'd3, 16'h3333, 1'b0});
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h08 || sel4 !== 3'd3) begin failures++; $display("FAIL drop_grant gnt=%h sel=%0d want 08/3", gnt4, sel4); end
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (valid4 && out_ready) begin
        b = sbq.pop_front(); checks++;
        if (sel4 !== b.sel || data4 !== b.data || last4 !== b.last) begin
          failures++; $display("FAIL drop_beat sel=%0d data=%h last=%b want %0d/%h/%b", sel4, data4, last4, b.sel, b.data, b.last);
        end
      end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL drop_left left=%0d want 0", sbq.size()); end
    sbq.delete();
    @(negedge clk);
    req4 = 8'h40;
    #1;
    checks++;
    if (valid4 !== 1'b0 || last4 !== 1'b0 || gnt4 !== 8'h08) begin
      failures++; $display("FAIL drop_cycle valid=%b last=%b gnt=%h want 0/0/08", valid4, last4, gnt4);
    end
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h40 || sel4 !== 3'd6 || data4 !== 16'h6666) begin
      failures++; $display("FAIL drop_handover gnt=%h sel=%0d data=%h want 40/6/6666", gnt4, sel4, data4);
    end
    req4 = 8'h09;
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h01 || sel4 !== 3'd0) begin failures++; $display("FAIL ptr_wrap gnt=%h sel=%0d want 01/0", gnt4, sel4); end
    req4 = 0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    beat_t b;
    @(negedge clk);
    din[111:96] = 16'h6A6A; din[127:112] = 16'h7777; req4 = 8'h40; out_ready = 1;
    sbq.push_back('{3'd6, 16'h6A6A, 1'b0});
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h40 || sel4 !== 3'd6) begin failures++; $display("FAIL ar_grant gnt=%h sel=%0d want 40/6", gnt4, sel4); end
    if (valid4 && out_ready) begin
      b = sbq.pop_front(); checks++;
      if (data4 !== b.data || last4 !== b.last) begin failures++; $display("FAIL ar_beat data=%h last=%b want %h/%b", data4, last4, b.data, b.last); end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL ar_left left=%0d want 0", sbq.size()); end
    sbq.delete();
    @(negedge clk);
    #2 reset = 1;
    req4 = 8'h80;
    #1;
    checks++;
    if (gnt4 !== 8'h00 || valid4 !== 1'b0 || data4 !== 16'h0000 || sel4 !== 3'd0 || last4 !== 1'b0) begin
      failures++; $display("FAIL ar_async gnt=%h valid=%b data=%h sel=%0d last=%b want 00/0/0000/0/0", gnt4, valid4, data4, sel4, last4);
    end
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h00 || valid4 !== 1'b0) begin failures++; $display("FAIL ar_held gnt=%h valid=%b want 00/0", gnt4, valid4); end
    reset = 0;
    @(negedge clk);
    checks++;
    if (gnt4 !== 8'h80 || sel4 !== 3'd7 || data4 !== 16'h7777 || valid4 !== 1'b1) begin
      failures++; $display("FAIL ar_release gnt=%h sel=%0d data=%h valid=%b want 80/7/7777/1", gnt4, sel4, data4, valid4);
    end
    req4 = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_backpressure();
    test_drop_pointer();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
